qpsk_bit_splitter: RTL and testbench

QPSK_BIT_SPLITTER -- requirements
Module: qpsk_bit_splitter

---
 rtl/qpsk_bit_splitter_if.sv | 30 +++
 rtl/qpsk_bit_splitter.sv | 153 +++++++++++++++
 tb/tb_qpsk_bit_splitter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/qpsk_bit_splitter_if.sv
// Stream bundle for the QPSK bit splitter: serial bit input with
// valid/ready/last, paired-bit output with valid/ready/last/pad, and
// the running symbol count.
interface qpsk_bit_splitter_if #(
  parameter int COUNT_W = 16
);
  logic               in_bit;
  logic               in_valid;
  logic               in_last;
  logic               in_ready;
  logic               out_odd;
  logic               out_even;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic               out_pad;
  logic [COUNT_W-1:0] sym_count;

  // Splitter side: consumes bits, produces pairs.
  modport slave (
    input  in_bit, in_valid, in_last, out_ready,
    output in_ready, out_odd, out_even, out_valid, out_last, out_pad, sym_count
  );

  // Environment side: produces bits, consumes pairs.
  modport master (
    output in_bit, in_valid, in_last, out_ready,
    input  in_ready, out_odd, out_even, out_valid, out_last, out_pad, sym_count
  );
endinterface

// File: rtl/qpsk_bit_splitter.sv
// QPSK bit splitter: groups a serial bit stream into (odd, even) pairs for
// the I/Q mapper. An odd-length frame is closed with a zero-padded pair.
// One output register slot; a new pair may replace the outgoing one in the
// same cycle, so a continuously ready sink sees one pair per two bits.
module qpsk_bit_splitter #(
  parameter int COUNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  qpsk_bit_splitter_if.slave    bus
);

  typedef enum logic [1:0] {
    WAIT_ODD  = 2'd0,
    WAIT_EVEN = 2'd1,
    PAD       = 2'd2
  } state_t;

  state_t             state;
  logic               held_bit;

  logic               vld_p1;
  logic               odd_p1;
  logic               even_p1;
  logic               last_p1;
  logic               pad_p1;
  logic [COUNT_W-1:0] sym_cnt;

  logic               in_ready;
  logic               slot_free;
  logic               in_hs;
  logic               out_hs;

  logic               load;
  logic               load_odd;
  logic               load_even;
  logic               load_last;
  logic               load_pad;

  // The output slot can take a new pair if it is empty or being drained now.
  assign slot_free = !vld_p1 || bus.out_ready;
  assign in_hs     = bus.in_valid && in_ready;
  assign out_hs    = vld_p1 && bus.out_ready;

  // Input acceptance depends on state; an even bit needs a free slot.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      WAIT_ODD:  in_ready = 1'b1;
      WAIT_EVEN: in_ready = slot_free;
      PAD:       in_ready = 1'b0;
      default:   in_ready = 1'b0;
    endcase
  end

  // Decide whether the output slot is written this cycle and with what.
  always_comb begin
    load      = 1'b0;
    load_odd  = 1'b0;
    load_even = 1'b0;
    load_last = 1'b0;
    load_pad  = 1'b0;
    case (state)
      WAIT_ODD: begin
        if (in_hs && bus.in_last && slot_free) begin
          load      = 1'b1;
          load_odd  = bus.in_bit;
          load_last = 1'b1;
          load_pad  = 1'b1;
        end
      end
      WAIT_EVEN: begin
        if (in_hs) begin
          load      = 1'b1;
          load_odd  = held_bit;
          load_even = bus.in_bit;
          load_last = bus.in_last;
        end
      end
      PAD: begin
        if (slot_free) begin
          load      = 1'b1;
          load_odd  = held_bit;
          load_last = 1'b1;
          load_pad  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ---- stage p0 -> p1: FSM, held odd bit, output slot and symbol counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= WAIT_ODD;
      held_bit <= 1'b0;
      vld_p1   <= 1'b0;
      odd_p1   <= 1'b0;
      even_p1  <= 1'b0;
      last_p1  <= 1'b0;
      pad_p1   <= 1'b0;
      sym_cnt  <= '0;
    end else begin
      if (out_hs) begin
        sym_cnt <= sym_cnt + {{(COUNT_W-1){1'b0}}, 1'b1};
      end

      // A load wins over a drain so back-to-back pairs leave no bubble.
      if (load) begin
        vld_p1  <= 1'b1;
        odd_p1  <= load_odd;
        even_p1 <= load_even;
        last_p1 <= load_last;
        pad_p1  <= load_pad;
      end else if (out_hs) begin
        vld_p1  <= 1'b0;
      end

      case (state)
        WAIT_ODD: begin
          if (in_hs) begin
            held_bit <= bus.in_bit;
            if (!bus.in_last) begin
              state <= WAIT_EVEN;
            end else if (!slot_free) begin
              state <= PAD;
            end
          end
        end
        WAIT_EVEN: begin
          if (in_hs) begin
            state <= WAIT_ODD;
          end
        end
        PAD: begin
          if (slot_free) begin
            state <= WAIT_ODD;
          end
        end
        default: state <= WAIT_ODD;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = vld_p1;
  assign bus.out_odd   = odd_p1;
  assign bus.out_even  = even_p1;
  assign bus.out_last  = last_p1;
  assign bus.out_pad   = pad_p1;
  assign bus.sym_count = sym_cnt;

endmodule

// File: tb/tb_qpsk_bit_splitter.sv
// Directed bench for qpsk_bit_splitter. A 16-bit-counter instance carries
// the main checks; a 2-bit-counter instance sees identical inputs so the
// counter wrap can be observed within a short run.
module tb_qpsk_bit_splitter;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  qpsk_bit_splitter_if #(.COUNT_W(16)) bus ();
  qpsk_bit_splitter_if #(.COUNT_W(2))  bus_w ();

  qpsk_bit_splitter #(.COUNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  qpsk_bit_splitter #(.COUNT_W(2)) dut_w (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_w.slave)
  );

  assign bus_w.in_bit    = bus.in_bit;
  assign bus_w.in_valid  = bus.in_valid;
  assign bus_w.in_last   = bus.in_last;
  assign bus_w.out_ready = bus.out_ready;

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic tog   = 1'b0;

  logic [3:0] pq[$];   // accepted pairs {odd, even, last, pad}
  int         pc[$];   // cycle of each output handshake
  int         ic[$];   // cycle of each input handshake

  always @(posedge clk) cyc <= cyc + 1;

  // Observe handshakes just before each rising edge.
  always begin
    @(negedge clk);
    #4;
    if (bus.out_valid && bus.out_ready) begin
      pq.push_back({bus.out_odd, bus.out_even, bus.out_last, bus.out_pad});
      pc.push_back(cyc);
    end
    if (bus.in_valid && bus.in_ready) begin
      ic.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    pq.delete();
    pc.delete();
    ic.delete();
  endtask

  // Present one bit starting at a falling edge; returns at the falling edge
  // after the handshake.
  task automatic send_bit(input logic b, input logic l);
    int  n;
    logic hs;
    n  = 0;
    hs = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_bit   = b;
    bus.in_last  = l;
    while (!hs && n < 50) begin
      #4;
      hs = bus.in_ready;
      @(negedge clk);
      n++;
    end
    if (!hs) chk("send_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Compare logged pairs with n nibbles packed MSB-first in exp.
  task automatic check_pairs(input string tag, input logic [31:0] exp, input int n);
    chk({tag, "_npairs"}, pq.size(), n);
    for (int k = 0; k < n; k++) begin
      if (k < pq.size()) chk({tag, "_pair"}, 32'(pq[k]), 32'(exp[4*(n-1-k) +: 4]));
    end
  endtask

  logic [7:0]  pat37 = 8'b0001_1011;
  logic [15:0] pat40 = 16'b1011_0010_0111_1000;

  initial begin
    bus.in_bit    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_outs", 32'({bus.out_valid, bus.out_odd, bus.out_even, bus.out_last, bus.out_pad}), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_count", 32'(bus.sym_count), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Basic streaming, latency, and 2-bit counter wrap
    clear_logs();
    for (int i = 0; i < 6; i++) send_bit(pat37[7-i], 1'b0);
    repeat (2) @(negedge clk);
    chk("stream_cnt3", 32'(bus.sym_count), 32'd3);
    chk("wrap_cnt3", 32'(bus_w.sym_count), 32'd3);
    for (int i = 6; i < 8; i++) send_bit(pat37[7-i], 1'b0);
    repeat (2) @(negedge clk);
    chk("stream_cnt4", 32'(bus.sym_count), 32'd4);
    chk("wrap_cnt0", 32'(bus_w.sym_count), 32'd0);
    check_pairs("stream", 32'h048C, 4);
    for (int k = 0; k < 4; k++) begin
      if (k < pc.size() && 2*k+1 < ic.size()) chk("stream_latency", 32'(pc[k] - ic[2*k+1]), 32'd1);
    end

    // Odd-length frame with free slot: immediate padded pair
    clear_logs();
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b1);
    repeat (3) @(negedge clk);
    check_pairs("padfree", 32'h8B, 2);
    chk("padfree_cnt", 32'(bus.sym_count), 32'd6);

    // Backpressure, stable outputs, PAD state, ordered drain
    clear_logs();
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    repeat (2) @(negedge clk);
    bus.out_ready = 1'b0;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold", 32'({bus.out_valid, bus.out_odd, bus.out_even, bus.out_last, bus.out_pad}), 32'b10100);
      @(negedge clk);
    end
    send_bit(1'b1, 1'b1);
    // Offered bits in PAD must not be taken.
    bus.in_valid = 1'b1;
    bus.in_bit   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("pad_in_ready", 32'(bus.in_ready), 32'd0);
      chk("pad_hold", 32'({bus.out_valid, bus.out_odd, bus.out_even, bus.out_last, bus.out_pad}), 32'b10100);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_pairs("drain", 32'hC4B, 3);
    if (pc.size() == 3) chk("drain_pad_gap", 32'(pc[2] - pc[1]), 32'd1);
    chk("drain_inputs", ic.size(), 5);
    chk("drain_cnt", 32'(bus.sym_count), 32'd9);
    chk("drain_in_ready", 32'(bus.in_ready), 32'd1);

    // Reset after only the odd bit of a pair
    clear_logs();
    send_bit(1'b1, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_outs", 32'({bus.out_valid, bus.out_odd, bus.out_even, bus.out_last, bus.out_pad}), 32'd0);
    chk("midrst_cnt", 32'(bus.sym_count), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check_pairs("midrst", 32'h4, 1);
    chk("midrst_cnt1", 32'(bus.sym_count), 32'd1);

    // 16 bits with out_ready toggling every cycle
    clear_logs();
    tog = 1'b1;
    fork
      begin
        for (int i = 0; i < 16; i++) send_bit(pat40[15-i], 1'b0);
        tog = 1'b0;
      end
      begin
        while (tog) begin
          @(negedge clk);
          bus.out_ready = ~bus.out_ready;
        end
      end
    join
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_pairs("toggle", 32'h8C084C80, 8);
    chk("toggle_cnt", 32'(bus.sym_count), 32'd9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
